mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Owns the single-port memory's shared 16-bit data_in bus, MAR load and write strobes.
//  Serves two requesters: CPU fetch/execute unit and DMA/program loader.
//  Round-robin arbitration between them.
//  Each granted transaction is sequenced as MAR load, then access, then a one-cycle ack.
//  Sits between the requesters and memory; nothing else drives the memory control pins.
// PARAMETERS
//  ADDR_W  16  address width; equals memory MAR width
//  DATA_W  8   memory word width; bus_out upper bits zero-filled on data phase
// PORTS
//  clk         in   1       system clock; all state on rising edge
//  rst         in   1       synchronous, active-high reset
//  cpu_req     in   1       CPU request; level, held until cpu_ack
//  cpu_we      in   1       1=write, 0=read; sampled at grant
//  cpu_addr    in   ADDR_W  sampled at grant
//  cpu_wdata   in   DATA_W  sampled at grant
//  cpu_ack     out  1       one-cycle completion pulse
//  cpu_rdata   out  DATA_W  read data; valid while cpu_ack=1, held until next CPU read
//  dma_req/dma_we/dma_addr/dma_wdata/dma_ack/dma_rdata  same as cpu_*, DMA port
//  mem_out     in   DATA_W  memory output (mem[MAR], combinational)
//  bus_out     out  ADDR_W  drives memory data_in
//  mar_we      out  1       drives memory mar_write_en
//  mem_we      out  1       drives memory mem_write_en
//  busy        out  1       1 in any state other than IDLE
//  owner       out  1       0=CPU, 1=DMA; owner of the current/last transaction
// BEHAVIOUR
//  Reset:
//  - state=IDLE; all outputs 0 (bus_out=0, acks=0, rdata=0, owner=0).
//  - last_grant=DMA, so CPU wins the first tie.
//  FSM: IDLE -> ADDR -> ACCESS -> DONE -> IDLE. A transaction is 3 cycles after grant.
//  Peak throughput is one transaction per 4 cycles.
//  - IDLE:
//    - No req: stay in IDLE.
//    - One req: grant it.
//    - Both: grant the requester != last_grant.
//    - On grant, latch we/addr/wdata into op registers, set owner and last_grant, go to ADDR.
//  - ADDR: bus_out=op_addr, mar_we=1, mem_we=0. Memory MAR loads at the closing edge.
//  - ACCESS, write: bus_out={zeros,op_wdata}, mem_we=1, mar_we=0.
//  - ACCESS, read: bus_out=0 and both strobes 0; owner's rdata <= mem_out at the closing edge.
//  - DONE: owner's ack=1 (registered), strobes 0, bus_out=0; go to IDLE.
//  - A req still high in the IDLE cycle after ack is a new request.
//  - Requesters drop req on the edge that ends the ack cycle.
//  Strobes and bus_out are decoded from registered state only; no req->strobe combinational path.
//  Non-owner signals:
//  - Changes on the non-owner port's inputs during a transaction are ignored.
//  - The non-owner's rdata is unchanged.
//  Reset mid-transaction:
//  - Reset during ADDR/ACCESS/DONE -> IDLE at that edge; no ack is issued.
//  - The edge that samples rst still commits any strobe already asserted in that cycle.
//  - Example: a write in ACCESS completes in memory but is never acked.
//  - Requesters must reissue after reset.
//  Addresses: full 16-bit range, no wrap logic; 0xFFFF is legal.
// STRUCTURE
//  Shared header nam85_defs.vh:
//  - FSM state encodings MA_IDLE=2'd0, MA_ADDR=2'd1, MA_ACCESS=2'd2, MA_DONE=2'd3.
//  - OWNER_CPU=1'b0, OWNER_DMA=1'b1.
//  Sub-module mem_rr_arb:
//  - 2-way round-robin picker: req[1:0] + last_grant -> grant_valid, grant_idx.
//  - Combinational, with last_grant register inside and an update enable.
//  Top level: FSM, op latches, per-port rdata registers and ack registers.
// TESTING
//  1. CPU write 0x1234<-0xA5: cycle1 bus_out=0x1234 mar_we=1; cycle2 bus_out=0x00A5 mem_we=1;
//     cycle3 cpu_ack=1; mem[0x1234]==0xA5.
//  2. CPU read 0x1234 after scenario 1: cpu_ack=1 with cpu_rdata=0xA5 exactly 3 cycles after grant;
//     mem_we never asserted.
//  3. cpu_req and dma_req held high together from reset:
//     grants alternate CPU, DMA, CPU, DMA; each ack 4 cycles apart.
//  4. DMA writes 0x00..0x0F to 0x0000..0x000F then CPU reads them back: every rdata matches;
//     dma_rdata untouched by CPU reads.
//  5. rst asserted during ACCESS of a DMA read: next cycle state=IDLE, busy=0, no dma_ack,
//     dma_rdata=0, all strobes 0.
//  6. Boundary: write 0x5A to 0xFFFF then read back 0x5A.
//     Also: dma_req toggling mid-CPU-transaction leaves bus_out/strobes and cpu results unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arbiter_pkg;

    localparam int MA_ADDR_W = 16;
    localparam int MA_DATA_W = 8;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'd0,
        MA_ADDR   = 2'd1,
        MA_ACCESS = 2'd2,
        MA_DONE   = 2'd3
    } ma_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports plus memory control pins of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_we, dma_ack;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic [DATA_W-1:0] mem_out;
    logic [ADDR_W-1:0] bus_out;
    logic              mar_we, mem_we, busy, owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, mem_out,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output bus_out, mar_we, mem_we, busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, mem_out,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  bus_out, mar_we, mem_we, busy, owner
    );
endinterface

// File: rtl/mem_rr_arb.sv
// Two-way round-robin picker; last_grant advances only when update is set.
module mem_rr_arb
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output logic       grant_idx
);
    logic last_grant;

    // On a tie the side that did not win last time goes next.
    always_comb begin
        grant_valid = |req;
        grant_idx   = (&req) ? ~last_grant : req[1];
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= OWNER_DMA;
        else if (update && grant_valid)
            last_grant <= grant_idx;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA onto the memory: MAR load, access, then one-cycle ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MA_ADDR_W,
    parameter int DATA_W = MA_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    ma_state_t         state, state_nxt;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              owner_q, cpu_ack_q, dma_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              grant_valid, grant_idx, grant;

    assign grant = (state == MA_IDLE) && grant_valid;

    mem_rr_arb u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         ({bus.dma_req, bus.cpu_req}),
        .update      (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Memory pins decode from registered state only, so req never reaches a strobe.
    always_comb begin
        state_nxt   = state;
        bus.bus_out = '0;
        bus.mar_we  = 1'b0;
        bus.mem_we  = 1'b0;
        case (state)
            MA_IDLE:   if (grant_valid) state_nxt = MA_ADDR;
            MA_ADDR: begin
                state_nxt   = MA_ACCESS;
                bus.bus_out = op_addr;
                bus.mar_we  = 1'b1;
            end
            MA_ACCESS: begin
                state_nxt = MA_DONE;
                if (op_we) begin
                    bus.bus_out = ADDR_W'(op_wdata);
                    bus.mem_we  = 1'b1;
                end
            end
            MA_DONE:   state_nxt = MA_IDLE;
            default:   state_nxt = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MA_IDLE;
            op_we       <= 1'b0;
            op_addr     <= '0;
            op_wdata    <= '0;
            owner_q     <= OWNER_CPU;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state     <= state_nxt;
            cpu_ack_q <= (state == MA_ACCESS) && (owner_q == OWNER_CPU);
            dma_ack_q <= (state == MA_ACCESS) && (owner_q == OWNER_DMA);
            if (grant) begin
                op_we    <= grant_idx ? bus.dma_we    : bus.cpu_we;
                op_addr  <= grant_idx ? bus.dma_addr  : bus.cpu_addr;
                op_wdata <= grant_idx ? bus.dma_wdata : bus.cpu_wdata;
                owner_q  <= grant_idx;
            end
            if (state == MA_ACCESS && !op_we) begin
                if (owner_q == OWNER_DMA) dma_rdata_q <= bus.mem_out;
                else                      cpu_rdata_q <= bus.mem_out;
            end
        end
    end

    assign bus.busy      = (state != MA_IDLE);
    assign bus.owner     = owner_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a memory, a transaction-level reference and a per-cycle compare.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    // Single-port memory: MAR and array, not affected by reset.
    logic [7:0]  tb_mem [0:65535];
    logic [15:0] mar = 16'h0;
    always @(posedge clk) begin
        if (bus.mar_we) mar <= bus.bus_out;
        if (bus.mem_we) tb_mem[mar] <= bus.bus_out[7:0];
    end
    assign bus.mem_out = tb_mem[mar];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: position inside a transaction (0 idle, 1..3 after grant) plus sparse memory.
    logic [7:0]  ref_mem [logic [15:0]];
    int          m_pos = 0;
    bit          m_own = 0, m_last = 1, m_we = 0, g;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_wd = 8'h0, m_cr = 8'h0, m_dr = 8'h0;

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (m_pos == 2 && m_we) ref_mem[m_addr] = m_wd;
            m_pos = 0; m_own = 0; m_last = 1; m_cr = 8'h0; m_dr = 8'h0;
        end else if (m_pos == 0) begin
            if (bus.cpu_req || bus.dma_req) begin
                g      = (bus.cpu_req && bus.dma_req) ? !m_last : bus.dma_req;
                m_we   = g ? bus.dma_we    : bus.cpu_we;
                m_addr = g ? bus.dma_addr  : bus.cpu_addr;
                m_wd   = g ? bus.dma_wdata : bus.cpu_wdata;
                m_own  = g; m_last = g; m_pos = 1;
            end
        end else begin
            if (m_pos == 2) begin
                if (m_we)       ref_mem[m_addr] = m_wd;
                else if (m_own) m_dr = ref_rd(m_addr);
                else            m_cr = ref_rd(m_addr);
            end
            m_pos = (m_pos == 3) ? 0 : m_pos + 1;
        end
    end

    bit saw_mem_we = 0;
    always @(negedge clk) begin
        if (bus.mem_we) saw_mem_we = 1;
        if (chk_en) begin
            chk("busy",      32'(bus.busy),      32'(m_pos != 0));
            chk("mar_we",    32'(bus.mar_we),    32'(m_pos == 1));
            chk("mem_we",    32'(bus.mem_we),    32'(m_pos == 2 && m_we));
            chk("bus_out",   32'(bus.bus_out),
                32'(m_pos == 1 ? m_addr : (m_pos == 2 && m_we) ? {8'h00, m_wd} : 16'h0));
            chk("cpu_ack",   32'(bus.cpu_ack),   32'(m_pos == 3 && !m_own));
            chk("dma_ack",   32'(bus.dma_ack),   32'(m_pos == 3 && m_own));
            chk("owner",     32'(bus.owner),     32'(m_own));
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cr));
            chk("dma_rdata", 32'(bus.dma_rdata), 32'(m_dr));
        end
    end

    // One transaction on a port; returns read data and edges from request to ack.
    task automatic txn(input bit port, input bit we, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] rdata, output int lat);
        bit found = 0;
        @(negedge clk);
        if (port) begin bus.dma_req = 1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d; end
        else      begin bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; end
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (port ? bus.dma_ack : bus.cpu_ack) found = 1;
        end
        chk("ack_seen", 32'(found), 32'd1);
        rdata = port ? bus.dma_rdata : bus.cpu_rdata;
        if (port) bus.dma_req = 0; else bus.cpu_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int lat;
        int ack_cyc[$];
        bit ack_who[$];
        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bus_out", 32'(bus.bus_out), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        rst = 0;

        // 1: CPU write 0x1234 <- 0xA5, cycle by cycle
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'hA5;
        @(negedge clk);
        chk("t1_addr_bus", 32'(bus.bus_out), 32'h1234);
        chk("t1_mar_we", 32'(bus.mar_we), 32'd1);
        @(negedge clk);
        chk("t1_data_bus", 32'(bus.bus_out), 32'h00A5);
        chk("t1_mem_we", 32'(bus.mem_we), 32'd1);
        @(negedge clk);
        chk("t1_ack", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 0;
        @(negedge clk);
        chk("t1_mem", 32'(tb_mem[16'h1234]), 32'hA5);

        // 2: CPU read back, 3 cycles from grant, no write strobe
        saw_mem_we = 0;
        txn(0, 0, 16'h1234, 8'h00, rd, lat);
        chk("t2_rdata", 32'(rd), 32'hA5);
        chk("t2_latency", 32'(lat), 32'd3);
        chk("t2_no_mem_we", 32'(saw_mem_we), 32'd0);

        // 3: both requests held from reset -> CPU, DMA, CPU, DMA, 4 cycles apart
        @(negedge clk);
        rst = 1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h1234;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0000;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 40 && ack_cyc.size() < 4; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin ack_cyc.push_back(cyc); ack_who.push_back(0); end
            if (bus.dma_ack) begin ack_cyc.push_back(cyc); ack_who.push_back(1); end
        end
        bus.cpu_req = 0; bus.dma_req = 0;
        chk("t3_ack_count", 32'(ack_cyc.size()), 32'd4);
        if (ack_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", 32'(ack_who[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) chk("t3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
        end

        // 4: DMA fills 0..15, DMA reads one, CPU reads all back
        for (int i = 0; i < 16; i++) txn(1, 1, 16'(i), 8'(i), rd, lat);
        txn(1, 0, 16'h0005, 8'h00, rd, lat);
        chk("t4_dma_rd", 32'(rd), 32'h05);
        for (int i = 0; i < 16; i++) begin
            txn(0, 0, 16'(i), 8'h00, rd, lat);
            chk("t4_cpu_rd", 32'(rd), 32'(i));
            chk("t4_dma_keep", 32'(bus.dma_rdata), 32'h05);
        end

        // 5: reset during ACCESS of a DMA read
        @(negedge clk);
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 16'h0003;
        repeat (2) @(negedge clk);
        rst = 1; bus.dma_req = 0;
        @(negedge clk);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_dma_ack", 32'(bus.dma_ack), 32'd0);
        chk("t5_dma_rdata", 32'(bus.dma_rdata), 32'd0);
        chk("t5_strobes", 32'({bus.mar_we, bus.mem_we}), 32'd0);
        rst = 0;
        // reset during ACCESS of a write: memory written, never acked
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0007; bus.cpu_wdata = 8'h77;
        repeat (2) @(negedge clk);
        rst = 1; bus.cpu_req = 0;
        @(negedge clk);
        chk("t5_wr_mem", 32'(tb_mem[16'h0007]), 32'h77);
        chk("t5_wr_no_ack", 32'(bus.cpu_ack), 32'd0);
        rst = 0;
        txn(0, 0, 16'h0007, 8'h00, rd, lat);
        chk("t5_wr_readback", 32'(rd), 32'h77);

        // 6: top address, then DMA toggling during a CPU write
        txn(0, 1, 16'hFFFF, 8'h5A, rd, lat);
        txn(0, 0, 16'hFFFF, 8'h00, rd, lat);
        chk("t6_ffff", 32'(rd), 32'h5A);
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 8'h3C;
        @(negedge clk);
        chk("t6_addr_bus", 32'(bus.bus_out), 32'h0100);
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'hBEEF; bus.dma_wdata = 8'hEE;
        @(negedge clk);
        chk("t6_data_bus", 32'(bus.bus_out), 32'h003C);
        chk("t6_owner", 32'(bus.owner), 32'd0);
        bus.dma_req = 0; bus.dma_addr = 16'h0;
        @(negedge clk);
        chk("t6_ack", 32'(bus.cpu_ack), 32'd1);
        chk("t6_no_dma_ack", 32'(bus.dma_ack), 32'd0);
        bus.cpu_req = 0;
        repeat (2) @(negedge clk);
        chk("t6_mem", 32'(tb_mem[16'h0100]), 32'h3C);
        chk("t6_beef", 32'(tb_mem[16'hBEEF]), 32'h00);
        chk("t6_idle", 32'(bus.busy), 32'd0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
